uart_rx_core: RTL and testbench

- 8-bit UART receiver with 16x oversampling, optional parity, and a small receive FIFO.
- Sits between the SoC's `uart_rx_i` pin and the UART register block.
- Produces the bytes that the SoC's transmitter-side peers send.
- Baud rate is set at run time by a divisor; received bytes are popped through a valid/ready handshake.

---
 rtl/uart_rx_core.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver with 16x oversampling, optional parity and a small receive FIFO.
// The line is synchronised, framed by a tick-driven FSM, and good bytes are queued for a valid/ready consumer.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 baud_div_i,
  input  logic                        rx_i,
  output logic [7:0]                  rdata_o,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overrun_o,
  input  logic                        clear_i,
  output logic                        busy_o
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  function automatic logic parity_exp(input logic [DATA_W-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  state_t              state;
  logic                rx_p0;
  logic                rx_p1;
  logic                rx_s;
  logic [15:0]         presc;
  logic                tick;
  logic [3:0]          tick_cnt;
  logic [2:0]          bit_cnt;
  logic                sample;
  logic                start_det;
  logic                par_bad;
  logic [1:0]          warm;
  logic                armed;
  logic [DATA_W-1:0]   shreg;
  logic                push;
  logic                pop;
  logic                full;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;

  // Stage p0/p1: two-flop synchroniser, idles high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Oversample tick generator, realigned to the start edge
  assign tick      = (presc == baud_div_i);
  assign start_det = (state == IDLE) && armed && !rx_s;
  assign sample    = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc <= '0;
    end else if (start_det || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Framing FSM; armed only goes high once rx_s reflects a genuinely high line after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      par_bad      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      busy_o       <= 1'b0;
      warm         <= '0;
      armed        <= 1'b0;
    end else begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      warm         <= {warm[0], 1'b1};
      if (warm[1] && rx_s) armed <= 1'b1;
      if (tick && (state inside {START, DATA, PARITY, STOP}))
        tick_cnt <= sample ? 4'd0 : tick_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            tick_cnt <= '0;
            busy_o   <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_W-1)) state <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample) begin
            par_bad <= (rx_s != parity_exp(shreg));
            state   <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (!rx_s) begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HIGH;
            end else begin
              parity_err_o <= par_bad;
              state        <= IDLE;
              busy_o       <= 1'b0;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == DATA && sample) shreg <= {rx_s, shreg[DATA_W-1:1]};
  end

  // Receive FIFO: simultaneous push and pop, a full FIFO still accepts a push alongside a pop
  assign push     = (state == STOP) && sample && rx_s && !par_bad;
  assign pop      = rvalid_o && rready_i;
  assign full     = (count == DEPTH_L);
  assign wr_en    = push && (!full || pop);
  assign rvalid_o = (count != '0);
  assign level_o  = count;
  assign rdata_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overrun_o <= 1'b1;
      else if (clear_i)         overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: one 8N1 and one 8E1 instance, checked every cycle against a frame-level
// scoreboard (expected FIFO contents as a queue, error pulses scheduled at the mid-stop sample).
module tb_uart_rx_core;

  localparam int  DEPTH  = 4;
  localparam bit  PODD1  = 1'b0;
  localparam int  K_PUSH = 0;
  localparam int  K_FE   = 1;
  localparam int  K_PE   = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div_a   [2];
  logic        rx_a    [2];
  logic        rready_a[2];
  logic        clear_a [2];

  logic [7:0]  rdata0, rdata1;
  logic        rvalid0, rvalid1, fe0, fe1, pe0, pe1, ovr0, ovr1, busy0, busy1;
  logic [2:0]  level0, level1;

  logic [7:0]  rdata_a [2];
  logic        rvalid_a[2];
  logic [2:0]  level_a [2];
  logic        fe_a    [2];
  logic        pe_a    [2];
  logic        ovr_a   [2];

  logic [7:0]  exp_q [2][$];
  ev_t         evq   [2][$];
  logic        exp_fe [2] = '{default: 1'b0};
  logic        exp_pe [2] = '{default: 1'b0};
  logic        exp_ovr[2] = '{default: 1'b0};

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  logic rand_on = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .baud_div_i(div_a[0]), .rx_i(rx_a[0]),
    .rdata_o(rdata0), .rvalid_o(rvalid0), .rready_i(rready_a[0]), .level_o(level0),
    .frame_err_o(fe0), .parity_err_o(pe0), .overrun_o(ovr0), .clear_i(clear_a[0]),
    .busy_o(busy0)
  );

  uart_rx_core #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(PODD1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .baud_div_i(div_a[1]), .rx_i(rx_a[1]),
    .rdata_o(rdata1), .rvalid_o(rvalid1), .rready_i(rready_a[1]), .level_o(level1),
    .frame_err_o(fe1), .parity_err_o(pe1), .overrun_o(ovr1), .clear_i(clear_a[1]),
    .busy_o(busy1)
  );

  always_comb begin
    rdata_a[0] = rdata0;  rdata_a[1] = rdata1;
    rvalid_a[0] = rvalid0; rvalid_a[1] = rvalid1;
    level_a[0] = level0;  level_a[1] = level1;
    fe_a[0] = fe0;        fe_a[1] = fe1;
    pe_a[0] = pe0;        pe_a[1] = pe1;
    ovr_a[0] = ovr0;      ovr_a[1] = ovr1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Frame-level reference: outcomes land on the cycle of the mid-stop sample
  always @(posedge clk or posedge rst) begin
    ev_t  ev;
    logic pop_now;
    logic push_now;
    logic set_ovr;
    logic [7:0] pdata;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        evq[i].delete();
        exp_fe[i]  = 1'b0;
        exp_pe[i]  = 1'b0;
        exp_ovr[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        exp_fe[i] = 1'b0;
        exp_pe[i] = 1'b0;
        push_now  = 1'b0;
        set_ovr   = 1'b0;
        pdata     = 8'h00;
        pop_now   = rready_a[i] && (exp_q[i].size() != 0);
        if (evq[i].size() != 0 && evq[i][0].cyc == cyc) begin
          ev = evq[i].pop_front();
          case (ev.kind)
            K_FE:    exp_fe[i] = 1'b1;
            K_PE:    exp_pe[i] = 1'b1;
            default: begin push_now = 1'b1; pdata = ev.data; end
          endcase
        end
        if (pop_now) void'(exp_q[i].pop_front());
        if (push_now) begin
          if (exp_q[i].size() < DEPTH) exp_q[i].push_back(pdata);
          else set_ovr = 1'b1;
        end
        if (set_ovr)         exp_ovr[i] = 1'b1;
        else if (clear_a[i]) exp_ovr[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rvalid%0d", i), 32'(rvalid_a[i]), 32'(exp_q[i].size() != 0));
      chk($sformatf("level%0d", i), 32'(level_a[i]), 32'(exp_q[i].size()));
      if (exp_q[i].size() != 0)
        chk($sformatf("rdata%0d", i), 32'(rdata_a[i]), 32'(exp_q[i][0]));
      chk($sformatf("frame_err%0d", i), 32'(fe_a[i]), 32'(exp_fe[i]));
      chk($sformatf("parity_err%0d", i), 32'(pe_a[i]), 32'(exp_pe[i]));
      chk($sformatf("overrun%0d", i), 32'(ovr_a[i]), 32'(exp_ovr[i]));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic pop1(input int inst);
    rready_a[inst] = 1'b1;
    idle(1);
    rready_a[inst] = 1'b0;
  endtask

  // Start edge at t0; 2 sync + 1 detect cycles, then 8 ticks to mid-start and 16 per bit after
  task automatic send_frame(input int inst, input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input int hold_bits);
    int   p;
    logic use_par;
    ev_t  ev;
    p       = int'(div_a[inst]) + 1;
    use_par = (inst == 1);
    @(posedge clk); #1;
    rx_a[inst] = 1'b0;
    ev.cyc  = cyc + 3 + (use_par ? 168 : 152) * p;
    ev.data = d;
    if (!stop_bit)                                   ev.kind = K_FE;
    else if (use_par && (par_bit != ((^d) ^ PODD1))) ev.kind = K_PE;
    else                                             ev.kind = K_PUSH;
    evq[inst].push_back(ev);
    idle(16 * p);
    for (int i = 0; i < 8; i++) begin
      rx_a[inst] = d[i];
      idle(16 * p);
    end
    if (use_par) begin
      rx_a[inst] = par_bit;
      idle(16 * p);
    end
    rx_a[inst] = stop_bit;
    idle(16 * p);
    if (!stop_bit) idle(16 * p * hold_bits);
    rx_a[inst] = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      div_a[i] = 16'd6; rx_a[i] = 1'b1; rready_a[i] = 1'b0; clear_a[i] = 1'b0;
    end
    idle(3);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_level0", 32'(level0), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_ovr0", 32'(ovr0), 0);
    chk("rst_fe0", 32'(fe0), 0);
    chk("rst_pe0", 32'(pe0), 0);
    chk("rst_level1", 32'(level1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    rst = 1'b0;
    idle(20);

    // 0xA5 8N1 at 112 clocks/bit: push lands 3 + 152*7 = 1067 cycles after the start edge
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
      begin
        int ts;
        ts = cyc + 1;
        wait_until(ts + 1066);
        chk("lat_before", 32'(rvalid0), 0);
        chk("busy_mid", 32'(busy0), 1);
        wait_until(ts + 1067);
        chk("lat_rise", 32'(rvalid0), 1);
      end
    join
    chk("a5_data", 32'(rdata0), 32'h A5);
    chk("a5_level", 32'(level0), 1);
    pop1(0);
    chk("a5_pop_valid", 32'(rvalid0), 0);
    chk("a5_pop_level", 32'(level0), 0);

    // false start: low for 3 ticks only
    idle(30);
    rx_a[0] = 1'b0;
    idle(3 * 7);
    rx_a[0] = 1'b1;
    idle(16 * 7);
    chk("false_busy", 32'(busy0), 0);
    chk("false_level", 32'(level0), 0);

    // framing error followed by a 20-bit break
    send_frame(0, 8'h3C, 1'b0, 1'b0, 20);
    chk("break_busy", 32'(busy0), 1);
    idle(40);
    chk("break_idle", 32'(busy0), 0);
    chk("break_level", 32'(level0), 0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    idle(20);
    chk("x81_data", 32'(rdata0), 32'h81);
    chk("x81_level", 32'(level0), 1);
    pop1(0);

    // even parity: 0x07 needs parity bit 1
    send_frame(1, 8'h07, 1'b1, 1'b1, 0);
    idle(20);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0);
    idle(20);
    chk("par_level", 32'(level1), 1);
    chk("par_data", 32'(rdata1), 32'h07);
    pop1(1);
    chk("par_pop", 32'(level1), 0);

    // overrun: five bytes into a four-entry FIFO
    for (int k = 1; k <= 5; k++) begin
      send_frame(0, 8'(k), 1'b0, 1'b1, 0);
      idle(10);
    end
    chk("ovr_level", 32'(level0), 4);
    chk("ovr_flag", 32'(ovr0), 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovr_pop%0d", k), 32'(rdata0), 32'(k));
      pop1(0);
    end
    chk("ovr_empty", 32'(rvalid0), 0);
    chk("ovr_sticky", 32'(ovr0), 1);
    clear_a[0] = 1'b1;
    idle(1);
    clear_a[0] = 1'b0;
    chk("ovr_clear", 32'(ovr0), 0);

    // reset in the middle of 0xFF's data bits
    idle(20);
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
      begin
        idle(3 + 8 * 7 + 16 * 7 * 3);
        chk("mid_busy", 32'(busy0), 1);
        rst = 1'b1;
        idle(2);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_level", 32'(level0), 0);
        rst = 1'b0;
      end
    join
    idle(20);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
    idle(20);
    chk("x5a_data", 32'(rdata0), 32'h5A);
    chk("x5a_level", 32'(level0), 1);
    pop1(0);

    // reset released onto a held-low line: ignored until the line returns high
    rx_a[0] = 1'b0;
    idle(50);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(12 * 16 * 7);
    chk("low_rst_busy", 32'(busy0), 0);
    rx_a[0] = 1'b1;
    idle(40);
    send_frame(0, 8'h3E, 1'b0, 1'b1, 0);
    idle(20);
    chk("x3e_level", 32'(level0), 1);
    chk("x3e_data", 32'(rdata0), 32'h3E);
    pop1(0);

    // randomized frames on both lines with random pops, clears and divisors
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
          rready_a[i] = ($urandom % 3 == 0);
          clear_a[i]  = ($urandom % 16 == 0);
        end
      end
    join_none
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d0, d1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      div_a[0] = 16'($urandom_range(0, 3));
      div_a[1] = 16'($urandom_range(0, 3));
      fork
        send_frame(0, d0, 1'b0, ($urandom % 6 != 0), 0);
        send_frame(1, d1, (^d1) ^ PODD1 ^ ($urandom % 4 == 0), ($urandom % 6 != 0), 0);
      join
      idle(10 + $urandom_range(0, 20));
    end
    rand_on = 1'b0;
    idle(3);
    rready_a[0] = 1'b1;
    rready_a[1] = 1'b1;
    clear_a[0]  = 1'b0;
    clear_a[1]  = 1'b0;
    idle(10);
    chk("drain_level0", 32'(level0), 0);
    chk("drain_level1", 32'(level1), 0);
    chk("drain_busy0", 32'(busy0), 0);
    chk("drain_busy1", 32'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
